ioctl_loader_bridge: RTL and testbench
======================================

# ioctl_loader_bridge

Buffered, multi-channel bridge between the HPS ioctl download port and the core's loader write port. It replaces the single-byte ldr_wr/ldr_ack/ldr_done handshake with a parametrised FIFO, so the HPS is stalled only when the buffer is nearly full. It routes each download to one of NCH loader channels selected by ioctl_index and reports per-channel busy/done. Done flags re-arm on every new download of the same channel. It sits in the emu top between hps_io and PC88MiSTer, clocked by clk_sys.

## Interface
- ADDR_W, 19: loader address width; ioctl_addr bits above are range-checked.
- DEPTH, 8: FIFO depth in entries, power of two, ≥4.
- NCH, 2: loader channel count; CH_W = max(1, clog2(NCH)).

Ports:
- clk_sys  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress, from hps_io.
- ioctl_index  in  8  download index; channel = ioctl_index when < NCH.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to hps_io.
- ldr_adr  out  ADDR_W  loader address, valid while ldr_wr=1.
- ldr_wdat  out  8  loader data, valid while ldr_wr=1.
- ldr_ch  out  CH_W  channel of the current download.
- ldr_wr  out  1  level write request.
- ldr_ack  in  1  core acknowledge; only the rising edge counts.
- ldr_oe  out  NCH  per-channel "loading" (downloading or draining).
- ldr_done  out  NCH  per-channel sticky completion.
- ldr_err  out  1  sticky: byte dropped (address out of range or FIFO overflow).

## Operation
- Download start (ioctl_download rising edge, registered) with a valid index c:
  - ldr_ch ← c; ldr_oe[c] ← 1; ldr_done[c] ← 0; ldr_err ← 0.
  - An invalid index (≥ NCH) sets no oe and clears no done. All bytes of that download are discarded and ioctl_wait stays 0.
- Accepted write: ioctl_wr=1 during a valid download, FIFO not full, and ioctl_addr < 2^ADDR_W. Pushes {ioctl_addr[ADDR_W-1:0], ioctl_dout}.
- Dropped write: address out of range, or FIFO full. Sets ldr_err; the FIFO is unchanged.
- ioctl_wait = (FIFO count ≥ DEPTH-1) OR (restart pending). The headroom of one entry absorbs the strobe already in flight.
- Restart pending: a new download starts while the FIFO is non-empty. ioctl_wait is held until the FIFO is empty. The old channel then completes, and only after that does the new channel become ldr_ch with oe set.
- Drain FSM:
  - IDLE → REQ when the FIFO is non-empty and ldr_ack=0. Loads head onto ldr_adr/ldr_wdat, ldr_wr ← 1.
  - REQ → WAITLOW on a registered ack rising edge (ldr_ack=1 and ack_q=0). ldr_wr ← 0 and pop.
  - WAITLOW → IDLE when ldr_ack=0.
  - ldr_adr/ldr_wdat are stable for the whole REQ state.
- Completion: the download has ended (falling edge seen) and FIFO empty and FSM in IDLE/WAITLOW with ack low. Then ldr_oe[c] ← 0 and ldr_done[c] ← 1 in the same cycle.
- A download falling edge with zero bytes still produces done on the following cycle.
- Simultaneous push and pop: count unchanged, both take effect.
- FIFO pointers wrap modulo DEPTH.

## Timing
- Reset values (async rstn=0): ioctl_wait=0, ldr_wr=0, ldr_adr=0, ldr_wdat=0, ldr_ch=0, ldr_oe=0, ldr_done=0, ldr_err=0, FIFO empty, FSM IDLE.
- Latency, empty FIFO, ack low: ioctl_wr at cycle t → entry visible at t+1 → ldr_wr=1 at t+2.
- Ack: ldr_ack first high at cycle a → ldr_wr=0 at a+2 (one register stage for edge detection, one for the update).
- Next request is no earlier than one cycle after ldr_ack is seen low.
- ioctl_wait asserts the cycle after the push that brings count to DEPTH-1. It deasserts the cycle after the pop that drops count below DEPTH-1.
- Done timing: ldr_done[c] rises 1 cycle after the completion condition is met; ldr_oe[c] falls in the same cycle.
- Reset mid-download: all state is cleared immediately. The next ioctl_download rising edge is required before any further byte is accepted.

## Test plan
- Single byte, ch0, ack 3 cycles after ldr_wr: addr=0x00010, data=0xA5 → ldr_adr=0x10 and ldr_wdat=0xA5 held until ack; then ldr_done=2'b01, ldr_oe=0.
- Backpressure, DEPTH=8, ack held low for 20 cycles, 10 back-to-back strobes → ioctl_wait=1 once 7 entries are queued; no byte lost; ldr_err=0; written data in address order.
- ioctl_addr=0x80000 with ADDR_W=19 → no ldr_wr, ldr_err=1; the following in-range byte is still written.
- Index 5 with NCH=2 → no loader writes, ldr_done unchanged, ioctl_wait=0.
- Re-download ch1 after done=2'b10 → done[1] clears at start, oe[1]=1, done[1] sets again at end; done[0] untouched.
- Restart while 4 entries are pending → ioctl_wait=1 until empty; old channel done; new channel oe only after drain.
- rstn pulsed low mid-drain → all outputs 0 immediately; FIFO empty.

Source files
------------

// File: rtl/ioctl_loader_bridge_if.sv
// Bundle of the HPS ioctl download port and the core loader write port.
// master: hps_io + core side (drives strobes and acks).
// slave: the bridge.
interface ioctl_loader_bridge_if #(
  parameter int ADDR_W = 19,
  parameter int NCH    = 2
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;

  logic [ADDR_W-1:0] ldr_adr;
  logic [7:0]        ldr_wdat;
  logic [CH_W-1:0]   ldr_ch;
  logic              ldr_wr;
  logic              ldr_ack;
  logic [NCH-1:0]    ldr_oe;
  logic [NCH-1:0]    ldr_done;
  logic              ldr_err;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait,
    input  ldr_adr, ldr_wdat, ldr_ch, ldr_wr, ldr_oe, ldr_done, ldr_err,
    output ldr_ack
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait,
    output ldr_adr, ldr_wdat, ldr_ch, ldr_wr, ldr_oe, ldr_done, ldr_err,
    input  ldr_ack
  );
endinterface

// File: rtl/ioctl_loader_bridge.sv
// Buffered multi-channel bridge from the hps_io ioctl download port to the
// core loader write port. Bytes are queued in a small FIFO and drained with a
// level-request / edge-acknowledge handshake. Per-channel busy/done flags are
// tracked, and a download restart is held off until the old one has drained.
module ioctl_loader_bridge #(
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 8,
  parameter int NCH    = 2
) (
  input  logic                 clk_sys,
  input  logic                 rstn,
  ioctl_loader_bridge_if.slave bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int EW   = ADDR_W + 8;

  typedef enum logic [1:0] {IDLE, REQ, WAITLOW} state_t;

  // FIFO storage and pointers
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;

  // download tracking
  logic              dl_q;       // registered ioctl_download
  logic              acc;        // bytes of the current download are accepted
  logic              busy;       // current channel still owes a completion
  logic              ended;      // falling edge seen for the current download
  logic              pend;       // restart waiting for the old download to drain
  logic [CH_W-1:0]   pend_ch;

  // loader side registers
  state_t            state;
  logic              ack_s, ack_q;
  logic              wr_reg;
  logic [ADDR_W-1:0] adr_reg;
  logic [7:0]        wdat_reg;
  logic [CH_W-1:0]   ch_reg;
  logic [NCH-1:0]    oe_reg, done_reg;
  logic              err_reg;

  logic              rise, fall, idx_ok, in_range, full;
  logic              push, drop, pop, complete, commit_pend;
  logic [CH_W-1:0]   new_ch;

  assign rise        = bus.ioctl_download & ~dl_q;
  assign fall        = ~bus.ioctl_download & dl_q;
  assign idx_ok      = (32'(bus.ioctl_index) < NCH);
  assign new_ch      = bus.ioctl_index[CH_W-1:0];
  assign in_range    = ((bus.ioctl_addr >> ADDR_W) == 25'd0);
  assign full        = (count == (PW+1)'(DEPTH));
  assign push        = bus.ioctl_wr & acc & ~full & in_range;
  assign drop        = bus.ioctl_wr & acc & (full | ~in_range);
  // Acknowledge edge is taken from the synchronised copy, one stage late.
  assign pop         = (state == REQ) & ack_s & ~ack_q;
  assign complete    = busy & (ended | fall) & (count == '0) & ~push
                     & (state != REQ) & ~ack_s;
  // A pending restart takes over only in the cycle after the old completion.
  assign commit_pend = pend & ~busy;

  assign bus.ioctl_wait = (count >= (PW+1)'(DEPTH-1)) | pend;
  assign bus.ldr_adr    = adr_reg;
  assign bus.ldr_wdat   = wdat_reg;
  assign bus.ldr_ch     = ch_reg;
  assign bus.ldr_wr     = wr_reg;
  assign bus.ldr_oe     = oe_reg;
  assign bus.ldr_done   = done_reg;
  assign bus.ldr_err    = err_reg;

  // FIFO data write; storage needs no reset since count guards reads
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= {bus.ioctl_addr[ADDR_W-1:0], bus.ioctl_dout};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Download start/end, restart hand-over and per-channel flags
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      // dl_q resets high so a download still asserted after reset is not
      // mistaken for a new start.
      dl_q     <= 1'b1;
      acc      <= 1'b0;
      busy     <= 1'b0;
      ended    <= 1'b0;
      pend     <= 1'b0;
      pend_ch  <= '0;
      ch_reg   <= '0;
      oe_reg   <= '0;
      done_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      dl_q <= bus.ioctl_download;
      if (drop) err_reg <= 1'b1;
      if (fall) begin
        acc   <= 1'b0;
        ended <= 1'b1;
      end
      if (complete) begin
        busy             <= 1'b0;
        oe_reg[ch_reg]   <= 1'b0;
        done_reg[ch_reg] <= 1'b1;
      end
      if (commit_pend) begin
        pend              <= 1'b0;
        ch_reg            <= pend_ch;
        oe_reg[pend_ch]   <= 1'b1;
        done_reg[pend_ch] <= 1'b0;
        err_reg           <= 1'b0;
        busy              <= 1'b1;
        ended             <= ~bus.ioctl_download;
        acc               <= bus.ioctl_download;
      end
      if (rise) begin
        if (!idx_ok) begin
          acc <= 1'b0;
        end else if (busy && !complete) begin
          pend    <= 1'b1;
          pend_ch <= new_ch;
          acc     <= 1'b0;
        end else begin
          ch_reg           <= new_ch;
          oe_reg[new_ch]   <= 1'b1;
          done_reg[new_ch] <= 1'b0;
          err_reg          <= 1'b0;
          busy             <= 1'b1;
          ended            <= 1'b0;
          acc              <= 1'b1;
        end
      end
    end
  end

  // Drain FSM: present head entry, wait for ack edge, then for ack release
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ack_s    <= 1'b0;
      ack_q    <= 1'b0;
      wr_reg   <= 1'b0;
      adr_reg  <= '0;
      wdat_reg <= '0;
    end else begin
      ack_s <= bus.ldr_ack;
      ack_q <= ack_s;
      case (state)
        IDLE: begin
          if (count != '0 && !ack_s) begin
            {adr_reg, wdat_reg} <= mem[rd_ptr];
            wr_reg              <= 1'b1;
            state               <= REQ;
          end
        end
        REQ: begin
          if (pop) begin
            wr_reg <= 1'b0;
            state  <= WAITLOW;
          end
        end
        WAITLOW: begin
          if (!ack_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ioctl_loader_bridge.sv
// Directed bench for ioctl_loader_bridge. Stimulus pushes the expected loader
// writes into a scoreboard queue; an independent core-side responder pops and
// compares each write as ldr_wr rises, then acknowledges it.
module tb_ioctl_loader_bridge;
  localparam int ADDR_W = 19;
  localparam int DEPTH  = 8;
  localparam int NCH    = 2;
  localparam int EW     = ADDR_W + 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ioctl_loader_bridge_if #(.ADDR_W(ADDR_W), .NCH(NCH)) bus ();

  ioctl_loader_bridge #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk_sys (clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  logic [EW-1:0] sb [$];
  int n_checks  = 0;
  int n_fail    = 0;
  int ack_delay = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    @(negedge clk);
  endtask

  // One byte strobe; honours ioctl_wait first. blocked reports a stall.
  task automatic strobe(input logic [24:0] a, input logic [7:0] d,
                        input bit expect_wr, output bit blocked);
    int g;
    g = 0;
    while (bus.ioctl_wait && g < 500) begin
      bus.ioctl_wr = 1'b0;
      @(negedge clk);
      g++;
    end
    if (g >= 500) chk("wait_timeout", 32'(bus.ioctl_wait), 32'd0);
    blocked = (g > 0);
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    if (expect_wr) sb.push_back({a[ADDR_W-1:0], d});
    $display("strobe addr=0x%07h data=0x%02h expect_write=%0d", a, d, expect_wr);
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input logic [NCH-1:0] mask, input string name);
    for (int i = 0; i < 600 && bus.ldr_done !== mask; i++) @(negedge clk);
    chk(name, 32'(bus.ldr_done), 32'(mask));
  endtask

  // Core-side responder and scoreboard checker
  initial begin : responder
    logic [EW-1:0] exp_e;
    logic prev_wr, stable, lat_a, lat_b, aborted;
    bus.ldr_ack = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_wr     = 1'b0;
        bus.ldr_ack = 1'b0;
      end else if (bus.ldr_wr && !prev_wr) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got adr=0x%0h dat=0x%0h, required no write",
                   bus.ldr_adr, bus.ldr_wdat);
          exp_e = {bus.ldr_adr, bus.ldr_wdat};
        end else begin
          exp_e = sb.pop_front();
          chk("ldr_adr", 32'(bus.ldr_adr), 32'(exp_e[EW-1:8]));
          chk("ldr_wdat", 32'(bus.ldr_wdat), 32'(exp_e[7:0]));
        end
        $display("loader write ch=%0d adr=0x%05h dat=0x%02h", bus.ldr_ch, bus.ldr_adr, bus.ldr_wdat);
        stable  = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < ack_delay && !aborted; k++) begin
          @(negedge clk);
          if (!rstn) aborted = 1'b1;
          else if (!(bus.ldr_wr && bus.ldr_adr == exp_e[EW-1:8] && bus.ldr_wdat == exp_e[7:0]))
            stable = 1'b0;
        end
        if (!aborted) begin
          chk("req_hold", 32'(stable), 32'd1);
          bus.ldr_ack = 1'b1;
          @(negedge clk);
          lat_a = bus.ldr_wr;
          if (!rstn) aborted = 1'b1;
          @(negedge clk);
          lat_b = bus.ldr_wr;
          if (!rstn) aborted = 1'b1;
          bus.ldr_ack = 1'b0;
          if (!aborted) chk("ack_lat", 32'({lat_a, lat_b}), 32'd2);
        end else begin
          bus.ldr_ack = 1'b0;
        end
        prev_wr = rstn ? bus.ldr_wr : 1'b0;
      end else begin
        prev_wr = bus.ldr_wr;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit blk;
    int first_block;
    bit early;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 25'd0;
    bus.ioctl_dout     = 8'd0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("rst_wr",   32'(bus.ldr_wr),     32'd0);
    chk("rst_adr",  32'(bus.ldr_adr),    32'd0);
    chk("rst_wdat", 32'(bus.ldr_wdat),   32'd0);
    chk("rst_ch",   32'(bus.ldr_ch),     32'd0);
    chk("rst_oe",   32'(bus.ldr_oe),     32'd0);
    chk("rst_done", 32'(bus.ldr_done),   32'd0);
    chk("rst_err",  32'(bus.ldr_err),    32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte on ch0, ack 3 cycles after ldr_wr
    ack_delay = 3;
    start_dl(8'd0);
    chk("t1_oe", 32'(bus.ldr_oe), 32'd1);
    strobe(25'h0000010, 8'hA5, 1'b1, blk);
    chk("t1_lat_t1", 32'(bus.ldr_wr), 32'd0);
    @(negedge clk);
    chk("t1_lat_t2", 32'(bus.ldr_wr), 32'd1);
    end_dl();
    wait_done(2'b01, "t1_done");
    chk("t1_oe_off", 32'(bus.ldr_oe), 32'd0);
    chk("t1_err", 32'(bus.ldr_err), 32'd0);

    // 2: backpressure, 10 back-to-back strobes with slow acks
    ack_delay   = 20;
    first_block = -1;
    start_dl(8'd0);
    chk("t2_done_rearm", 32'(bus.ldr_done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      strobe(25'h100 + 25'(i), 8'(i * 3 + 1), 1'b1, blk);
      if (blk && first_block < 0) first_block = i;
    end
    chk("t2_wait_at_7", 32'(first_block), 32'd7);
    end_dl();
    wait_done(2'b01, "t2_done");
    chk("t2_err", 32'(bus.ldr_err), 32'd0);
    chk("t2_all_written", 32'(sb.size()), 32'd0);

    // 3: out-of-range address dropped, next byte still written
    ack_delay = 1;
    start_dl(8'd0);
    strobe(25'h0080000, 8'h11, 1'b0, blk);
    strobe(25'h0000020, 8'h22, 1'b1, blk);
    end_dl();
    wait_done(2'b01, "t3_done");
    chk("t3_err", 32'(bus.ldr_err), 32'd1);

    // 4: invalid index, everything discarded
    start_dl(8'd5);
    for (int i = 0; i < 3; i++) begin
      strobe(25'h40 + 25'(i), 8'h50 + 8'(i), 1'b0, blk);
      chk("t4_wait", 32'(bus.ioctl_wait), 32'd0);
    end
    end_dl();
    repeat (10) @(negedge clk);
    chk("t4_done", 32'(bus.ldr_done), 32'd1);
    chk("t4_oe", 32'(bus.ldr_oe), 32'd0);

    // 5: ch1 download, then re-download ch1
    start_dl(8'd1);
    chk("t5_err_clr", 32'(bus.ldr_err), 32'd0);
    strobe(25'h0000200, 8'h61, 1'b1, blk);
    strobe(25'h0000201, 8'h62, 1'b1, blk);
    end_dl();
    wait_done(2'b11, "t5_done_a");
    start_dl(8'd1);
    chk("t5_rearm_done", 32'(bus.ldr_done), 32'd1);
    chk("t5_rearm_oe", 32'(bus.ldr_oe), 32'd2);
    chk("t5_ch", 32'(bus.ldr_ch), 32'd1);
    strobe(25'h0000300, 8'h77, 1'b1, blk);
    end_dl();
    wait_done(2'b11, "t5_done_b");
    chk("t5_oe_off", 32'(bus.ldr_oe), 32'd0);

    // 6: restart on ch1 while ch0 entries are still queued
    ack_delay = 15;
    start_dl(8'd0);
    for (int i = 0; i < 4; i++) strobe(25'h400 + 25'(i), 8'h80 + 8'(i), 1'b1, blk);
    end_dl();
    start_dl(8'd1);
    chk("t6_wait_pend", 32'(bus.ioctl_wait), 32'd1);
    chk("t6_oe_old", 32'(bus.ldr_oe), 32'd1);
    chk("t6_ch_old", 32'(bus.ldr_ch), 32'd0);
    early = 1'b0;
    for (int i = 0; i < 600 && !bus.ldr_oe[1]; i++) begin
      if (!bus.ioctl_wait) early = 1'b1;
      @(negedge clk);
    end
    chk("t6_wait_held", 32'(early), 32'd0);
    chk("t6_oe_new", 32'(bus.ldr_oe), 32'd2);
    chk("t6_done_old", 32'(bus.ldr_done), 32'd1);
    chk("t6_drained", 32'(sb.size()), 32'd0);
    chk("t6_ch_new", 32'(bus.ldr_ch), 32'd1);
    chk("t6_wait_rel", 32'(bus.ioctl_wait), 32'd0);
    ack_delay = 1;
    strobe(25'h0000005, 8'h33, 1'b1, blk);
    end_dl();
    wait_done(2'b11, "t6_done_new");

    // 7: reset pulse in the middle of a drain
    ack_delay = 10;
    start_dl(8'd0);
    for (int i = 0; i < 3; i++) strobe(25'h500 + 25'(i), 8'h90 + 8'(i), 1'b1, blk);
    for (int i = 0; i < 50 && !bus.ldr_wr; i++) @(negedge clk);
    chk("t7_draining", 32'(bus.ldr_wr), 32'd1);
    @(negedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("t7_wr",   32'(bus.ldr_wr),     32'd0);
    chk("t7_adr",  32'(bus.ldr_adr),    32'd0);
    chk("t7_oe",   32'(bus.ldr_oe),     32'd0);
    chk("t7_done", 32'(bus.ldr_done),   32'd0);
    chk("t7_wait", 32'(bus.ioctl_wait), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    // download is still high: no new start, so this byte must be ignored
    strobe(25'h0000600, 8'hEE, 1'b0, blk);
    repeat (8) @(negedge clk);
    chk("t7_no_write", 32'(bus.ldr_wr), 32'd0);
    end_dl();
    repeat (4) @(negedge clk);
    chk("t7_done_after", 32'(bus.ldr_done), 32'd0);
    ack_delay = 1;
    start_dl(8'd1);
    strobe(25'h0000700, 8'h3C, 1'b1, blk);
    end_dl();
    wait_done(2'b10, "t7_done_new");

    repeat (10) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
